// File: rtl/isp_pkg.sv
// -----------------------------------------------------------------------------
// isp_pkg
// Shared definitions for the ISP two-pass stage sequencer:
//   - datapath mode encodings (IDLE, STAGE14, STAGE56) and MODE_BIT_CNT
//   - sequencer state enumeration
//   - small decode helpers used by the top level
// -----------------------------------------------------------------------------
package isp_pkg;

  localparam int MODE_BIT_CNT = 2;

  localparam logic [MODE_BIT_CNT-1:0] MODE_IDLE    = 2'd0;
  localparam logic [MODE_BIT_CNT-1:0] MODE_STAGE14 = 2'd1;
  localparam logic [MODE_BIT_CNT-1:0] MODE_STAGE56 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_S14_FEED  = 3'd1,
    ST_S14_DRAIN = 3'd2,
    ST_SWITCH    = 3'd3,
    ST_S56_FEED  = 3'd4,
    ST_S56_DRAIN = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERR       = 3'd7
  } seq_state_e;

  // Datapath mode presented while sitting in a given state.
  function automatic logic [MODE_BIT_CNT-1:0] mode_of_state(input seq_state_e st);
    logic [MODE_BIT_CNT-1:0] m;
    case (st)
      ST_S14_FEED, ST_S14_DRAIN:           m = MODE_STAGE14;
      ST_SWITCH, ST_S56_FEED, ST_S56_DRAIN: m = MODE_STAGE56;
      default:                              m = MODE_IDLE;
    endcase
    return m;
  endfunction

  function automatic logic is_feed(input seq_state_e st);
    return (st == ST_S14_FEED) || (st == ST_S56_FEED);
  endfunction

  function automatic logic is_drain(input seq_state_e st);
    return (st == ST_S14_DRAIN) || (st == ST_S56_DRAIN);
  endfunction

endpackage

// File: rtl/isp_beat_pacer.sv
// -----------------------------------------------------------------------------
// isp_beat_pacer
// Enforces the minimum spacing between accepted upstream beats.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   feed_i         : sequencer is in a FEED state
//   stage56_i      : current FEED state is the STAGE56 pass (selects GAP56)
//   src_valid_i    : upstream beat available
//   src_ready_o    : FEED and gap counter drained (combinational)
//   accept_o       : beat accepted this cycle (valid & ready)
// -----------------------------------------------------------------------------
module isp_beat_pacer
  import isp_pkg::*;
#(
  parameter int GAP14 = 3,
  parameter int GAP56 = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic feed_i,
  input  logic stage56_i,
  input  logic src_valid_i,
  output logic src_ready_o,
  output logic accept_o
);

  localparam int GAP_MAX = (GAP14 > GAP56) ? GAP14 : GAP56;
  localparam int CNT_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
  localparam logic [CNT_W-1:0] LOAD14 = CNT_W'(GAP14 - 1);
  localparam logic [CNT_W-1:0] LOAD56 = CNT_W'(GAP56 - 1);

  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_d;

  assign src_ready_o = feed_i & (gap_q == {CNT_W{1'b0}});
  assign accept_o    = src_valid_i & src_ready_o;

  // Gap counter: reload on accept, otherwise count down and rest at zero.
  // It keeps running outside FEED so a stale gap from an aborted pass
  // still holds off the first beat of the next one.
  always_comb begin
    gap_d = gap_q;
    if (accept_o) begin
      gap_d = stage56_i ? LOAD56 : LOAD14;
    end else if (gap_q != {CNT_W{1'b0}}) begin
      gap_d = gap_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      gap_d = gap_q;
    end
  end

  // Gap counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= {CNT_W{1'b0}};
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/isp_stage_sequencer.sv
// -----------------------------------------------------------------------------
// isp_stage_sequencer
// Runs the ISP datapath through two passes: STAGE14 feed/drain, a settle
// interval after the mode switch, then STAGE56 feed/drain.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start_i, abort_i         : run start pulse / synchronous abort
//   src_valid_i, src_last_i  : upstream beat and last-beat-of-pass marker
//   src_ready_o              : upstream beat accepted when valid & ready
//   isp_valid_o, isp_mode_o  : datapath valid_in (combinational), mode_in (registered)
//   isp_finish_i             : datapath finish_operation
//   out_valid_i, out_last_pic_i : datapath output monitor (last picture seen)
//   busy_o, done_o, err_o    : run status
// Optional feature: define ISP_SEQ_TIMEOUT_EN to build a drain watchdog that
// enters ERR after TIMEOUT_CYC cycles in a DRAIN state. Without it err_o is 0.
// -----------------------------------------------------------------------------
module isp_stage_sequencer
  import isp_pkg::*;
#(
  parameter int GAP14       = 3,
  parameter int GAP56       = 1,
  parameter int SETTLE      = 30,
  parameter int TIMEOUT_CYC = 4194304
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    src_valid_i,
  input  logic                    src_last_i,
  output logic                    src_ready_o,
  output logic                    isp_valid_o,
  output logic [MODE_BIT_CNT-1:0] isp_mode_o,
  input  logic                    isp_finish_i,
  input  logic                    out_valid_i,
  input  logic                    out_last_pic_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

  seq_state_e              state_q, state_d;
  logic [MODE_BIT_CNT-1:0] mode_q, mode_d;
  logic                    last_seen_q, last_seen_d;
  logic [SET_W-1:0]        settle_q, settle_d;
  logic                    accept;
  logic                    last_hit;
  logic                    drain_exit;
  logic                    timeout_hit;

  isp_beat_pacer #(
    .GAP14 (GAP14),
    .GAP56 (GAP56)
  ) u_pacer (
    .clk         (clk),
    .rst         (rst),
    .feed_i      (is_feed(state_q)),
    .stage56_i   (state_q == ST_S56_FEED),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .accept_o    (accept)
  );

  assign isp_valid_o = accept;
  assign last_hit    = out_valid_i & out_last_pic_i;
  // A last-picture flag raised in the same cycle as finish still counts.
  assign drain_exit  = (last_seen_q | last_hit) & isp_finish_i;

`ifdef ISP_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog next value: count while staying in a DRAIN state, zero otherwise.
  always_comb begin
    wd_d = {WD_W{1'b0}};
    if (is_drain(state_q) && (state_d == state_q)) begin
      wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
    end else begin
      wd_d = {WD_W{1'b0}};
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= {WD_W{1'b0}};
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout_hit = is_drain(state_q) && (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign err_o       = (state_q == ST_ERR);
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  // Next-state, settle counter, last-picture flag and mode decode.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) state_d = ST_S14_FEED;
          else         state_d = state_q;
        end
        ST_S14_FEED: begin
          if (accept && src_last_i) state_d = ST_S14_DRAIN;
          else                      state_d = state_q;
        end
        ST_S14_DRAIN: begin
          if (drain_exit) begin
            state_d  = ST_SWITCH;
            settle_d = SETTLE_LOAD;
          end else if (timeout_hit) begin
            state_d = ST_ERR;
          end else begin
            state_d = state_q;
          end
        end
        ST_SWITCH: begin
          if (settle_q == {SET_W{1'b0}}) state_d = ST_S56_FEED;
          else settle_d = settle_q - {{(SET_W-1){1'b0}}, 1'b1};
        end
        ST_S56_FEED: begin
          if (accept && src_last_i) state_d = ST_S56_DRAIN;
          else                      state_d = state_q;
        end
        ST_S56_DRAIN: begin
          if (drain_exit)       state_d = ST_DONE;
          else if (timeout_hit) state_d = ST_ERR;
          else                  state_d = state_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The flag is cleared on FEED entry, which wins over a same-cycle set.
    if (is_feed(state_d) && (state_d != state_q)) begin
      last_seen_d = 1'b0;
    end else if (last_hit) begin
      last_seen_d = 1'b1;
    end else begin
      last_seen_d = last_seen_q;
    end

    // Mode is registered from the next state so it lines up with state_q.
    mode_d = mode_of_state(state_d);
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_IDLE;
      last_seen_q <= 1'b0;
      settle_q    <= {SET_W{1'b0}};
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      last_seen_q <= last_seen_d;
      settle_q    <= settle_d;
    end
  end

  assign isp_mode_o = mode_q;
  assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_isp_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_isp_stage_sequencer
// Self-checking bench. The reference model describes a run as a pass number
// (0 = not running, 1 = STAGE14, 2 = STAGE56) plus draining / settling
// sub-phases and a "cycles since last accepted beat" spacing rule.
// Inputs change on the falling edge; outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_isp_stage_sequencer;
  import isp_pkg::*;

  localparam int GAP14       = 3;
  localparam int GAP56       = 1;
  localparam int SETTLE      = 30;
  localparam int TIMEOUT_CYC = 16;
`ifdef ISP_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start_i, abort_i, src_valid_i, src_last_i;
  logic isp_finish_i, out_valid_i, out_last_pic_i;
  logic src_ready_o, isp_valid_o, busy_o, done_o, err_o;
  logic [MODE_BIT_CNT-1:0] isp_mode_o;

  always #5 clk = ~clk;

  isp_stage_sequencer #(
    .GAP14(GAP14), .GAP56(GAP56), .SETTLE(SETTLE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .src_valid_i(src_valid_i), .src_last_i(src_last_i), .src_ready_o(src_ready_o),
    .isp_valid_o(isp_valid_o), .isp_mode_o(isp_mode_o), .isp_finish_i(isp_finish_i),
    .out_valid_i(out_valid_i), .out_last_pic_i(out_last_pic_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int m_pass, m_settle, m_since, m_hold, m_wd;
  bit m_drain, m_done, m_err, m_ls;
  bit e_ready, e_valid, e_busy;
  logic [MODE_BIT_CNT-1:0] e_mode;

  task automatic model_reset();
    m_pass = 0; m_settle = 0; m_since = 1000; m_hold = 1; m_wd = 0;
    m_drain = 0; m_done = 0; m_err = 0; m_ls = 0;
  endtask

  task automatic predict();
    bit feeding;
    feeding = (m_pass != 0) && !m_drain && (m_settle == 0);
    e_ready = feeding && (m_since >= m_hold);
    e_valid = e_ready && src_valid_i;
    e_mode  = (m_pass == 1) ? MODE_STAGE14 : (m_pass == 2) ? MODE_STAGE56 : MODE_IDLE;
    e_busy  = (m_pass != 0);
  endtask

  task automatic model_edge();
    bit acc, hit, feed_entry;
    predict();
    acc = e_valid;
    hit = out_valid_i && out_last_pic_i;
    feed_entry = 1'b0;
    if (acc) begin
      m_since = 1;
      m_hold  = (m_pass == 1) ? GAP14 : GAP56;
    end else if (m_since < 1000) begin
      m_since++;
    end
    if (abort_i) begin
      m_pass = 0; m_drain = 0; m_settle = 0; m_done = 0; m_err = 0;
    end else if (m_pass == 0) begin
      if (start_i) begin m_pass = 1; m_done = 0; m_err = 0; feed_entry = 1'b1; end
    end else if (m_drain) begin
      if ((m_ls || hit) && isp_finish_i) begin
        m_drain = 0;
        if (m_pass == 1) begin m_pass = 2; m_settle = SETTLE; end
        else begin m_pass = 0; m_done = 1; end
      end else if (TO_EN && (m_wd == TIMEOUT_CYC - 1)) begin
        m_drain = 0; m_pass = 0; m_err = 1;
      end else begin
        m_wd++;
      end
    end else if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) feed_entry = 1'b1;
    end else if (acc && src_last_i) begin
      m_drain = 1; m_wd = 0;
    end
    m_ls = feed_entry ? 1'b0 : (m_ls || hit);
  endtask

  function automatic logic [6:0] dut_vec();
    return {src_ready_o, isp_valid_o, isp_mode_o, busy_o, done_o, err_o};
  endfunction

  function automatic logic [6:0] exp_vec();
    return {e_ready, e_valid, e_mode, e_busy, m_done, m_err};
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic drive(input bit st, ab, v, l, f, ov, olp);
    start_i = st; abort_i = ab; src_valid_i = v; src_last_i = l;
    isp_finish_i = f; out_valid_i = ov; out_last_pic_i = olp;
    #1;
    predict();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (dut_vec() !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", dut_vec(), 7'b0);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_stage14_feed();
    int acc_cyc[$];
    int beats = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 40 && beats < 8; c++) begin
      drive(1'b0, 1'b0, 1'b1, beats == 7, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL s14_cycle%0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
      if (isp_valid_o) begin acc_cyc.push_back(c); beats++; end
      tick();
    end
    n_checks++;
    if (acc_cyc.size() != 8) begin
      n_fail++; $display("FAIL s14_beat_count: got %0d expected 8", acc_cyc.size());
    end
    for (int i = 0; i < acc_cyc.size(); i++) begin
      n_checks++;
      if (acc_cyc[i] != GAP14 * i) begin
        n_fail++; $display("FAIL s14_accept_cycle%0d: got %0d expected %0d", i, acc_cyc[i], GAP14 * i);
      end
    end
  endtask

  task automatic test_switch();
    int low_cnt = 0;
    for (int c = 0; c <= 5; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, c == 5, c == 0, c == 0);
      n_checks++;
      if (dut_vec() !== exp_vec() || busy_o !== 1'b1 || src_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL s14_drain_cycle%0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
      tick();
    end
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (src_ready_o) break;
      if (isp_mode_o === MODE_STAGE56) low_cnt++;
      tick();
    end
    n_checks++;
    if (low_cnt != SETTLE) begin
      n_fail++; $display("FAIL switch_settle_cycles: got %0d expected %0d", low_cnt, SETTLE);
    end
    n_checks++;
    if (src_ready_o !== 1'b1 || isp_mode_o !== MODE_STAGE56) begin
      n_fail++; $display("FAIL s56_feed_entry: ready %b mode %0d expected ready 1 mode %0d",
                         src_ready_o, isp_mode_o, MODE_STAGE56);
    end
  endtask

  task automatic test_stage56_b2b();
    int beats = 0;
    int first = -1;
    int last  = -1;
    for (int c = 0; c < 20 && beats < 6; c++) begin
      drive(1'b0, 1'b0, 1'b1, beats == 5, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL s56_cycle%0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
      if (isp_valid_o) begin
        if (first < 0) first = c;
        last = c; beats++;
      end
      tick();
    end
    n_checks++;
    if (beats != 6 || last - first != 5) begin
      n_fail++; $display("FAIL s56_back_to_back: beats %0d span %0d expected 6 and 5", beats, last - first);
    end
    // last picture and finish in the same cycle
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL run_done: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic run_to_s56();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    for (int c = 0; c < 50 && !(m_pass == 2 && m_settle == 0); c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_abort();
    run_to_s56();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (src_ready_o !== 1'b1 || isp_mode_o !== MODE_STAGE56) begin
      n_fail++; $display("FAIL abort_precondition: ready %b mode %0d expected 1 and %0d",
                         src_ready_o, isp_mode_o, MODE_STAGE56);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dut_vec() !== {1'b0, 1'b0, MODE_IDLE, 1'b0, 1'b0, 1'b0} || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL abort_to_idle: got %b expected %b", dut_vec(), exp_vec());
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_start_ignored: busy %b expected 0", busy_o);
    end
  endtask

  task automatic test_rst_mid();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (isp_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_accept: isp_valid %b expected 1", isp_valid_o);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec() !== 7'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %b expected %b", dut_vec(), 7'b0);
    end
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL rst_release: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_drain_watchdog();
    int err_at = -1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (err_o === 1'b1) begin err_at = c; break; end
      tick();
    end
    n_checks++;
    if (TO_EN && err_at != TIMEOUT_CYC) begin
      n_fail++; $display("FAIL watchdog_err: at cycle %0d expected %0d", err_at, TIMEOUT_CYC);
    end else if (!TO_EN && err_at != -1) begin
      n_fail++; $display("FAIL err_tied_low: err at cycle %0d expected never", err_at);
    end
    // start restarts from ERR; without the watchdog abort first to leave DRAIN
    drive(1'b1, !TO_EN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if (!TO_EN) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (busy_o !== 1'b1 || err_o !== 1'b0 || isp_mode_o !== MODE_STAGE14 || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL restart_s14: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stage14_feed();
    test_switch();
    test_stage56_b2b();
    test_abort();
    test_rst_mid();
    test_drain_watchdog();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
